// File: rtl/sys_array_tile_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : sys_array_tile_scheduler
// Brief    : Walks a large matrix product over a fixed systolic core, one tile
//            at a time (k innermost, then column, then row).
// Revision : 1.0 - initial release
// ============================================================================
module sys_array_tile_scheduler #(
    parameter int ARRAY_A_W     = 4,
    parameter int ARRAY_A_L     = 5,
    parameter int ARRAY_W_L     = 8,
    parameter int ARRAY_W       = 5,
    parameter int ARRAY_L       = 5,
    parameter int ARRAY_MAX_A_W = 5,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_comp,
    input  logic             tile_done,
    output logic             busy,
    output logic             ready,
    output logic             tile_start,
    output logic             acc_clear,
    output logic             tile_last,
    output logic [CNT_W-1:0] a_row_base,
    output logic [CNT_W-1:0] k_base,
    output logic [CNT_W-1:0] w_col_base,
    output logic [CNT_W-1:0] tile_rows,
    output logic [CNT_W-1:0] tile_k,
    output logic [CNT_W-1:0] tile_cols,
    output logic [CNT_W-1:0] tile_idx
);

    localparam int c_nr      = (ARRAY_A_W + ARRAY_MAX_A_W - 1) / ARRAY_MAX_A_W;
    localparam int c_nk      = (ARRAY_A_L + ARRAY_W - 1) / ARRAY_W;
    localparam int c_nc      = (ARRAY_W_L + ARRAY_L - 1) / ARRAY_L;
    localparam int c_n_tiles = c_nr * c_nk * c_nc;

    localparam logic [CNT_W-1:0] c_last_idx = CNT_W'(c_n_tiles - 1);
    localparam logic [CNT_W-1:0] c_a_w      = CNT_W'(ARRAY_A_W);
    localparam logic [CNT_W-1:0] c_a_l      = CNT_W'(ARRAY_A_L);
    localparam logic [CNT_W-1:0] c_w_l      = CNT_W'(ARRAY_W_L);
    localparam logic [CNT_W-1:0] c_k_step   = CNT_W'(ARRAY_W);
    localparam logic [CNT_W-1:0] c_col_step = CNT_W'(ARRAY_L);
    localparam logic [CNT_W-1:0] c_row_step = CNT_W'(ARRAY_MAX_A_W);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_WAIT    = 3'd2,
        S_ADVANCE = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_a_row_base;
    logic [CNT_W-1:0] r_k_base;
    logic [CNT_W-1:0] r_w_col_base;
    logic [CNT_W-1:0] r_tile_idx;
    logic             w_launch;
    logic             w_step;
    logic             w_last;
    logic             w_active;
    logic [CNT_W-1:0] w_k_next;
    logic [CNT_W-1:0] w_col_next;
    logic             w_k_wrap;
    logic             w_col_wrap;
    logic [CNT_W-1:0] w_rows_rem;
    logic [CNT_W-1:0] w_k_rem;
    logic [CNT_W-1:0] w_cols_rem;

    assign w_last     = (r_tile_idx == c_last_idx);
    assign w_k_next   = r_k_base + c_k_step;
    assign w_col_next = r_w_col_base + c_col_step;
    assign w_k_wrap   = (w_k_next >= c_a_l);
    assign w_col_wrap = (w_col_next >= c_w_l);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_launch     = 1'b0;
        w_step       = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start_comp) begin
                    w_state_next = S_ISSUE;
                    w_launch     = 1'b1;
                end
            end
            S_ISSUE: w_state_next = S_WAIT;
            S_WAIT: begin
                if (tile_done) begin
                    w_state_next = S_ADVANCE;
                end
            end
            S_ADVANCE: begin
                if (w_last) begin
                    w_state_next = S_DONE;
                end else begin
                    w_state_next = S_ISSUE;
                    w_step       = 1'b1;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Odometer over (row, col, k) with k as the fastest digit.
    always_ff @(posedge clk) begin
        if (reset || w_launch) begin
            r_a_row_base <= '0;
            r_k_base     <= '0;
            r_w_col_base <= '0;
            r_tile_idx   <= '0;
        end else if (w_step) begin
            r_tile_idx <= r_tile_idx + 1'b1;
            if (!w_k_wrap) begin
                r_k_base <= w_k_next;
            end else begin
                r_k_base <= '0;
                if (!w_col_wrap) begin
                    r_w_col_base <= w_col_next;
                end else begin
                    r_w_col_base <= '0;
                    r_a_row_base <= r_a_row_base + c_row_step;
                end
            end
        end
    end

    // Remainders are only used when base < dimension, so they never wrap.
    assign w_active   = (r_state != S_IDLE);
    assign w_rows_rem = c_a_w - r_a_row_base;
    assign w_k_rem    = c_a_l - r_k_base;
    assign w_cols_rem = c_w_l - r_w_col_base;

    assign tile_rows = (w_active && (r_a_row_base < c_a_w))
                     ? ((w_rows_rem < c_row_step) ? w_rows_rem : c_row_step) : '0;
    assign tile_k    = (w_active && (r_k_base < c_a_l))
                     ? ((w_k_rem < c_k_step) ? w_k_rem : c_k_step) : '0;
    assign tile_cols = (w_active && (r_w_col_base < c_w_l))
                     ? ((w_cols_rem < c_col_step) ? w_cols_rem : c_col_step) : '0;

    assign busy       = (r_state == S_ISSUE) || (r_state == S_WAIT) || (r_state == S_ADVANCE);
    assign ready      = (r_state == S_DONE);
    assign tile_start = (r_state == S_ISSUE);
    assign acc_clear  = w_active && (r_k_base == '0);
    assign tile_last  = w_active && w_last;
    assign a_row_base = r_a_row_base;
    assign k_base     = r_k_base;
    assign w_col_base = r_w_col_base;
    assign tile_idx   = r_tile_idx;

endmodule
`default_nettype wire

// File: tb/tb_sys_array_tile_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_sys_array_tile_scheduler
// Brief    : Randomized bench for three scheduler configurations against a
//            nested-loop tile model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sys_array_tile_scheduler;

    localparam int CNT_W = 16;
    localparam int N_DUT = 3;

    logic             clk = 1'b0;
    logic             reset      [N_DUT];
    logic             start_comp [N_DUT];
    logic             tile_done  [N_DUT];
    logic             busy       [N_DUT];
    logic             ready      [N_DUT];
    logic             tile_start [N_DUT];
    logic             acc_clear  [N_DUT];
    logic             tile_last  [N_DUT];
    logic [CNT_W-1:0] a_row_base [N_DUT];
    logic [CNT_W-1:0] k_base     [N_DUT];
    logic [CNT_W-1:0] w_col_base [N_DUT];
    logic [CNT_W-1:0] tile_rows  [N_DUT];
    logic [CNT_W-1:0] tile_k     [N_DUT];
    logic [CNT_W-1:0] tile_cols  [N_DUT];
    logic [CNT_W-1:0] tile_idx   [N_DUT];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    // dut0: defaults, dut1: ARRAY_W = 2, dut2: ARRAY_A_W = 12
    generate
        for (genvar d = 0; d < N_DUT; d++) begin : g_dut
            sys_array_tile_scheduler #(
                .ARRAY_A_W    ((d == 2) ? 12 : 4),
                .ARRAY_A_L    (5),
                .ARRAY_W_L    (8),
                .ARRAY_W      ((d == 1) ? 2 : 5),
                .ARRAY_L      (5),
                .ARRAY_MAX_A_W(5),
                .CNT_W        (CNT_W)
            ) u_dut (
                .clk       (clk),
                .reset     (reset[d]),
                .start_comp(start_comp[d]),
                .tile_done (tile_done[d]),
                .busy      (busy[d]),
                .ready     (ready[d]),
                .tile_start(tile_start[d]),
                .acc_clear (acc_clear[d]),
                .tile_last (tile_last[d]),
                .a_row_base(a_row_base[d]),
                .k_base    (k_base[d]),
                .w_col_base(w_col_base[d]),
                .tile_rows (tile_rows[d]),
                .tile_k    (tile_k[d]),
                .tile_cols (tile_cols[d]),
                .tile_idx  (tile_idx[d])
            );
        end
    endgenerate

    typedef struct {
        int row;
        int k;
        int col;
        int rows;
        int kk;
        int cols;
        int idx;
        bit clr;
        bit last;
    } tile_t;

    tile_t exp_q[$];

    function automatic int cfg_a_w(input int d);
        return (d == 2) ? 12 : 4;
    endfunction

    function automatic int cfg_arr_w(input int d);
        return (d == 1) ? 2 : 5;
    endfunction

    function automatic int min2(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic build_model(input int d);
        int aw;
        int aw_core;
        int nt;
        int n;
        aw      = cfg_a_w(d);
        aw_core = cfg_arr_w(d);
        nt      = ((aw + 4) / 5) * ((5 + aw_core - 1) / aw_core) * ((8 + 4) / 5);
        n       = 0;
        exp_q.delete();
        for (int r = 0; r < aw; r += 5) begin
            for (int c = 0; c < 8; c += 5) begin
                for (int k = 0; k < 5; k += aw_core) begin
                    tile_t t;
                    t.row  = r;
                    t.k    = k;
                    t.col  = c;
                    t.rows = min2(5, aw - r);
                    t.kk   = min2(aw_core, 5 - k);
                    t.cols = min2(5, 8 - c);
                    t.idx  = n;
                    t.clr  = (k == 0);
                    t.last = (n == nt - 1);
                    exp_q.push_back(t);
                    n++;
                end
            end
        end
    endtask

    function automatic logic [113:0] obs_fields(input int d);
        return {a_row_base[d], k_base[d], w_col_base[d], tile_rows[d], tile_k[d],
                tile_cols[d], tile_idx[d], acc_clear[d], tile_last[d]};
    endfunction

    function automatic logic [113:0] exp_fields(input tile_t t);
        return {16'(t.row), 16'(t.k), 16'(t.col), 16'(t.rows), 16'(t.kk),
                16'(t.cols), 16'(t.idx), t.clr, t.last};
    endfunction

    function automatic logic [2:0] obs_ctrl(input int d);
        return {busy[d], ready[d], tile_start[d]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic kick(input int d, input bit hold_start);
        start_comp[d] = 1'b1;
        tick();
        if (!hold_start) start_comp[d] = 1'b0;
        n_checks++;
        if (obs_ctrl(d) !== 3'b101)
            $display("FAIL kick dut%0d: busy/ready/tile_start got %b expected 101", d, obs_ctrl(d));
        else
            n_pass++;
    endtask

    // Entered in the ISSUE cycle of tile 0; leaves in the DONE cycle.
    task automatic run_tiles(input int d, input bit hold_done, input bit hold_start,
                             input bit poke_start, input int fixed_gap);
        for (int i = 0; i < exp_q.size(); i++) begin
            tile_t        t;
            logic [113:0] e;
            int           gap;
            t = exp_q[i];
            e = exp_fields(t);
            n_checks++;
            if (obs_ctrl(d) !== 3'b101)
                $display("FAIL issue_ctrl dut%0d tile%0d: got %b expected 101", d, i, obs_ctrl(d));
            else
                n_pass++;
            n_checks++;
            if (obs_fields(d) !== e)
                $display("FAIL issue_fields dut%0d tile%0d: got %h expected %h", d, i, obs_fields(d), e);
            else
                n_pass++;

            tile_done[d] = hold_done;
            tick();
            if (hold_done)           gap = 0;
            else if (fixed_gap >= 0) gap = fixed_gap;
            else                     gap = int'($urandom_range(poke_start ? 1 : 0, 4));
            for (int g = 0; g <= gap; g++) begin
                n_checks++;
                if (obs_ctrl(d) !== 3'b100 || obs_fields(d) !== e)
                    $display("FAIL wait_hold dut%0d tile%0d: got %b/%h expected 100/%h",
                             d, i, obs_ctrl(d), obs_fields(d), e);
                else
                    n_pass++;
                if (g < gap) begin
                    if (poke_start && g == 0) start_comp[d] = 1'b1;
                    tick();
                    start_comp[d] = hold_start;
                end
            end

            tile_done[d] = 1'b1;
            tick();
            tile_done[d] = 1'b0;
            n_checks++;
            if (obs_ctrl(d) !== 3'b100 || obs_fields(d) !== e)
                $display("FAIL advance dut%0d tile%0d: got %b/%h expected 100/%h",
                         d, i, obs_ctrl(d), obs_fields(d), e);
            else
                n_pass++;
            tick();
        end
        n_checks++;
        if (obs_ctrl(d) !== 3'b010)
            $display("FAIL done_ready dut%0d: got %b expected 010", d, obs_ctrl(d));
        else
            n_pass++;
    endtask

    task automatic test_reset();
        for (int d = 0; d < N_DUT; d++) begin
            n_checks++;
            if ({obs_ctrl(d), obs_fields(d)} !== 117'd0)
                $display("FAIL reset dut%0d: got %h expected 0", d, {obs_ctrl(d), obs_fields(d)});
            else
                n_pass++;
        end
    endtask

    task automatic test_idle_ignores_done();
        for (int d = 0; d < N_DUT; d++) tile_done[d] = 1'b1;
        tick();
        tick();
        for (int d = 0; d < N_DUT; d++) tile_done[d] = 1'b0;
        tick();
        for (int d = 0; d < N_DUT; d++) begin
            n_checks++;
            if ({obs_ctrl(d), obs_fields(d)} !== 117'd0)
                $display("FAIL idle_done dut%0d: got %h expected 0", d, {obs_ctrl(d), obs_fields(d)});
            else
                n_pass++;
        end
    endtask

    task automatic test_default_two_tiles();
        build_model(0);
        kick(0, 1'b0);
        run_tiles(0, 1'b0, 1'b0, 1'b0, 9);
    endtask

    task automatic test_k_chunks();
        build_model(1);
        kick(1, 1'b0);
        run_tiles(1, 1'b0, 1'b0, 1'b0, -1);
    endtask

    task automatic test_row_tiles();
        build_model(2);
        kick(2, 1'b0);
        run_tiles(2, 1'b0, 1'b0, 1'b0, -1);
    endtask

    task automatic test_done_filtering();
        build_model(0);
        kick(0, 1'b0);
        run_tiles(0, 1'b1, 1'b0, 1'b0, -1);
    endtask

    task automatic test_reset_mid_wait();
        build_model(1);
        kick(1, 1'b0);
        start_comp[1] = 1'b1;
        tick();
        start_comp[1] = 1'b0;
        tick();
        reset[1] = 1'b1;
        tick();
        reset[1] = 1'b0;
        n_checks++;
        if ({obs_ctrl(1), obs_fields(1)} !== 117'd0)
            $display("FAIL reset_mid_wait: got %h expected 0", {obs_ctrl(1), obs_fields(1)});
        else
            n_pass++;
        kick(1, 1'b0);
        run_tiles(1, 1'b0, 1'b0, 1'b1, -1);
    endtask

    task automatic test_start_held();
        build_model(0);
        kick(0, 1'b1);
        run_tiles(0, 1'b0, 1'b1, 1'b0, -1);
        tick();
        start_comp[0] = 1'b0;
        run_tiles(0, 1'b0, 1'b0, 1'b0, -1);
        tick();
        n_checks++;
        if (obs_ctrl(0) !== 3'b010)
            $display("FAIL ready_persist: got %b expected 010", obs_ctrl(0));
        else
            n_pass++;
    endtask

    task automatic test_random_jobs();
        for (int rep = 0; rep < 9; rep++) begin
            int d;
            d = int'($urandom_range(0, N_DUT - 1));
            build_model(d);
            kick(d, 1'b0);
            run_tiles(d, 1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)), -1);
        end
    endtask

    initial begin
        for (int d = 0; d < N_DUT; d++) begin
            reset[d]      = 1'b1;
            start_comp[d] = 1'b0;
            tile_done[d]  = 1'b0;
        end
        tick();
        tick();
        for (int d = 0; d < N_DUT; d++) reset[d] = 1'b0;
        tick();
        test_reset();
        test_idle_ignores_done();
        test_default_two_tiles();
        test_k_chunks();
        test_row_tiles();
        test_done_filtering();
        test_reset_mid_wait();
        test_start_held();
        test_random_jobs();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
